reg_rename_file: RTL and testbench



---
 rtl/reg_rename_file.sv | 110 +++++++++++
 tb/tb_reg_rename_file.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/reg_rename_file.sv
// Architectural register file with per-register rename state (busy + producing
// ROB tag). Two combinational source queries with commit forwarding, one
// rename port from decode, one commit port and a misbranch flush from the ROB.
module reg_rename_file #(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned REG_TAG_W = 5,
    parameter int unsigned ROB_TAG_W = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rdy,

    input  logic [REG_TAG_W-1:0] in_decode_reg_tag1,
    output logic [DATA_W-1:0]    out_decode_value1,
    output logic [ROB_TAG_W-1:0] out_decode_robtag1,
    output logic                 out_decode_busy1,

    input  logic [REG_TAG_W-1:0] in_decode_reg_tag2,
    output logic [DATA_W-1:0]    out_decode_value2,
    output logic [ROB_TAG_W-1:0] out_decode_robtag2,
    output logic                 out_decode_busy2,

    input  logic [REG_TAG_W-1:0] in_decode_destination,
    input  logic [ROB_TAG_W-1:0] in_decode_rob_tag,

    input  logic [REG_TAG_W-1:0] in_rob_commit_destination,
    input  logic [DATA_W-1:0]    in_rob_commit_value,
    input  logic [ROB_TAG_W-1:0] in_rob_commit_rob_tag,
    input  logic                 in_rob_misbranch
);

    localparam int unsigned NUM_REGS = 1 << REG_TAG_W;
    localparam int unsigned RD_W     = DATA_W + 1 + ROB_TAG_W;

    // Entry 0 is never written, so x0 stays zero in state as well.
    logic [NUM_REGS-1:0][DATA_W-1:0]    data_q, data_d;
    logic [NUM_REGS-1:0]                busy_q, busy_d;
    logic [NUM_REGS-1:0][ROB_TAG_W-1:0] tag_q,  tag_d;

    logic commit_vld;
    logic rename_vld;

    assign commit_vld = (in_rob_commit_rob_tag != '0) && (in_rob_commit_destination != '0);
    assign rename_vld = (in_decode_rob_tag != '0) && (in_decode_destination != '0);

    // Pre-edge lookup of one register, bypassing a matching commit; packed as {value, busy, tag}.
    function automatic logic [RD_W-1:0] read_port(input logic [REG_TAG_W-1:0] idx);
        logic fwd;
        fwd = commit_vld && (in_rob_commit_destination == idx) && (idx != '0)
              && busy_q[idx] && (tag_q[idx] == in_rob_commit_rob_tag);
        if (fwd) begin
            return {in_rob_commit_value, 1'b0, {ROB_TAG_W{1'b0}}};
        end else if (idx == '0) begin
            return {RD_W{1'b0}};
        end else if (busy_q[idx]) begin
            return {data_q[idx], 1'b1, tag_q[idx]};
        end else begin
            return {data_q[idx], 1'b0, {ROB_TAG_W{1'b0}}};
        end
    endfunction

    // Query port 1.
    always_comb begin
        {out_decode_value1, out_decode_busy1, out_decode_robtag1} = read_port(in_decode_reg_tag1);
    end

    // Query port 2.
    always_comb begin
        {out_decode_value2, out_decode_busy2, out_decode_robtag2} = read_port(in_decode_reg_tag2);
    end

    // Next state: commit first, then flush or rename (rename wins over commit's clear).
    always_comb begin
        data_d = data_q;
        busy_d = busy_q;
        tag_d  = tag_q;

        if (commit_vld) begin
            data_d[in_rob_commit_destination] = in_rob_commit_value;
            // A younger rename of the same register keeps its mapping.
            if (busy_q[in_rob_commit_destination]
                && (tag_q[in_rob_commit_destination] == in_rob_commit_rob_tag)) begin
                busy_d[in_rob_commit_destination] = 1'b0;
                tag_d[in_rob_commit_destination]  = '0;
            end
        end

        if (in_rob_misbranch) begin
            busy_d = '0;
            tag_d  = '0;
        end else if (rename_vld) begin
            busy_d[in_decode_destination] = 1'b1;
            tag_d[in_decode_destination]  = in_decode_rob_tag;
        end
    end

    // State registers; frozen while rdy is low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q <= '0;
            busy_q <= '0;
            tag_q  <= '0;
        end else if (rdy) begin
            data_q <= data_d;
            busy_q <= busy_d;
            tag_q  <= tag_d;
        end
    end

endmodule

// File: tb/tb_reg_rename_file.sv
// Bench for reg_rename_file: a register/rename model checked every cycle, plus
// directed scenarios with literal expectations.
module tb_reg_rename_file;

    logic        clk;
    logic        rst;
    logic        rdy;
    logic [4:0]  q1_idx, q2_idx;
    logic [31:0] v1, v2;
    logic [3:0]  t1, t2;
    logic        b1, b2;
    logic [4:0]  ren_dst;
    logic [3:0]  ren_tag;
    logic [4:0]  cm_dst;
    logic [31:0] cm_val;
    logic [3:0]  cm_tag;
    logic        misb;

    int n_cmp = 0;
    int n_err = 0;

    // Model: what each architectural register holds and which ROB entry owns it.
    logic [31:0] m_data [32];
    logic        m_busy [32];
    logic [3:0]  m_tag  [32];

    reg_rename_file dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .in_decode_reg_tag1(q1_idx), .out_decode_value1(v1),
        .out_decode_robtag1(t1), .out_decode_busy1(b1),
        .in_decode_reg_tag2(q2_idx), .out_decode_value2(v2),
        .out_decode_robtag2(t2), .out_decode_busy2(b2),
        .in_decode_destination(ren_dst), .in_decode_rob_tag(ren_tag),
        .in_rob_commit_destination(cm_dst), .in_rob_commit_value(cm_val),
        .in_rob_commit_rob_tag(cm_tag), .in_rob_misbranch(misb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Expected answer of a query from the model, including commit bypass.
    task automatic model_rd(input logic [4:0] idx, output logic [31:0] v,
                            output logic b, output logic [3:0] t);
        if (idx == 5'd0) begin
            v = 32'd0; b = 1'b0; t = 4'd0;
        end else if (cm_tag != 4'd0 && cm_dst == idx && m_busy[idx] && m_tag[idx] == cm_tag) begin
            v = cm_val; b = 1'b0; t = 4'd0;
        end else begin
            v = m_data[idx]; b = m_busy[idx]; t = m_busy[idx] ? m_tag[idx] : 4'd0;
        end
    endtask

    // Model update at the clock edge / async reset.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < 32; r++) begin
                m_data[r] = 32'd0; m_busy[r] = 1'b0; m_tag[r] = 4'd0;
            end
        end else if (rdy) begin
            logic clear_ok;
            clear_ok = (cm_tag != 4'd0 && cm_dst != 5'd0 && m_busy[cm_dst] && m_tag[cm_dst] == cm_tag);
            if (cm_tag != 4'd0 && cm_dst != 5'd0) m_data[cm_dst] = cm_val;
            if (clear_ok) begin
                m_busy[cm_dst] = 1'b0; m_tag[cm_dst] = 4'd0;
            end
            if (misb) begin
                for (int r = 0; r < 32; r++) begin
                    m_busy[r] = 1'b0; m_tag[r] = 4'd0;
                end
            end else if (ren_tag != 4'd0 && ren_dst != 5'd0) begin
                m_busy[ren_dst] = 1'b1; m_tag[ren_dst] = ren_tag;
            end
        end
    end

    // Every-cycle comparison on the falling edge, when inputs and state are stable.
    always @(negedge clk) begin
        logic [31:0] ev; logic eb; logic [3:0] et;
        model_rd(q1_idx, ev, eb, et);
        chk("p1_value", v1, ev); chk("p1_busy", 32'(b1), 32'(eb)); chk("p1_robtag", 32'(t1), 32'(et));
        model_rd(q2_idx, ev, eb, et);
        chk("p2_value", v2, ev); chk("p2_busy", 32'(b2), 32'(eb)); chk("p2_robtag", 32'(t2), 32'(et));
    end

    // Literal expectation on one query port.
    task automatic lit(input string nm, input int port, input logic [31:0] ev,
                       input logic eb, input logic [3:0] et);
        if (port == 1) begin
            chk({nm, "_v1"}, v1, ev); chk({nm, "_b1"}, 32'(b1), 32'(eb)); chk({nm, "_t1"}, 32'(t1), 32'(et));
        end else begin
            chk({nm, "_v2"}, v2, ev); chk({nm, "_b2"}, 32'(b2), 32'(eb)); chk({nm, "_t2"}, 32'(t2), 32'(et));
        end
    endtask

    task automatic idle();
        ren_dst = 5'd0; ren_tag = 4'd0; cm_dst = 5'd0; cm_val = 32'd0; cm_tag = 4'd0; misb = 1'b0;
    endtask

    // Advance to just after the next rising edge; then settle before literal checks.
    task automatic cyc();
        @(posedge clk);
        #1;
        idle();
    endtask

    initial begin
        rst = 1'b1; rdy = 1'b1; q1_idx = 5'd0; q2_idx = 5'd0;
        idle();
        #12 rst = 1'b0;
        cyc();

        // Reset state and x0 hard-wiring.
        q1_idx = 5'd5; q2_idx = 5'd0;
        cm_dst = 5'd0; cm_val = 32'hDEADBEEF; cm_tag = 4'd1;
        #2; lit("rst_x5", 1, 32'd0, 1'b0, 4'd0); lit("rst_x0", 2, 32'd0, 1'b0, 4'd0);
        cyc();
        q1_idx = 5'd0;
        #2; lit("x0_after_commit", 1, 32'd0, 1'b0, 4'd0);

        // Rename, then commit with forwarding.
        ren_dst = 5'd3; ren_tag = 4'd2; q1_idx = 5'd3;
        #2; lit("x3_rename_same_cycle", 1, 32'd0, 1'b0, 4'd0);
        cyc(); q1_idx = 5'd3;
        #2; lit("x3_busy", 1, 32'd0, 1'b1, 4'd2);
        cm_dst = 5'd3; cm_val = 32'h1234; cm_tag = 4'd2;
        #2; lit("x3_forward", 1, 32'h1234, 1'b0, 4'd0);
        cyc();
        #2; lit("x3_committed", 1, 32'h1234, 1'b0, 4'd0);

        // Double rename; stale commit must not clear busy.
        ren_dst = 5'd4; ren_tag = 4'd1; cyc();
        ren_dst = 5'd4; ren_tag = 4'd5; cyc();
        q2_idx = 5'd4; cm_dst = 5'd4; cm_val = 32'd7; cm_tag = 4'd1;
        #2; lit("x4_stale_no_fwd", 2, 32'd0, 1'b1, 4'd5);
        cyc();
        #2; lit("x4_after_stale", 2, 32'd7, 1'b1, 4'd5);
        cm_dst = 5'd4; cm_val = 32'd9; cm_tag = 4'd5;
        #2; lit("x4_fwd_young", 2, 32'd9, 1'b0, 4'd0);
        cyc();
        #2; lit("x4_final", 2, 32'd9, 1'b0, 4'd0);

        // Same-cycle commit and rename of one register.
        cm_dst = 5'd6; cm_val = 32'hAA; cm_tag = 4'd3; ren_dst = 5'd6; ren_tag = 4'd6; q1_idx = 5'd6;
        cyc();
        #2; lit("x6_commit_rename", 1, 32'hAA, 1'b1, 4'd6);

        // Misbranch with concurrent commit and rename.
        ren_dst = 5'd7; ren_tag = 4'd4; cyc();
        ren_dst = 5'd8; ren_tag = 4'd5; cyc();
        q1_idx = 5'd7; q2_idx = 5'd8;
        #2; lit("x7_pre_flush", 1, 32'd0, 1'b1, 4'd4); lit("x8_pre_flush", 2, 32'd0, 1'b1, 4'd5);
        misb = 1'b1; cm_dst = 5'd9; cm_val = 32'h55; cm_tag = 4'd1; ren_dst = 5'd10; ren_tag = 4'd6;
        cyc(); q1_idx = 5'd7; q2_idx = 5'd8;
        #2; lit("x7_flushed", 1, 32'd0, 1'b0, 4'd0); lit("x8_flushed", 2, 32'd0, 1'b0, 4'd0);
        q1_idx = 5'd10; q2_idx = 5'd9;
        #1; lit("x10_dropped", 1, 32'd0, 1'b0, 4'd0); lit("x9_data", 2, 32'h55, 1'b0, 4'd0);
        q1_idx = 5'd6;
        #1; lit("x6_flushed", 1, 32'hAA, 1'b0, 4'd0);

        // rdy low freezes state.
        rdy = 1'b0; ren_dst = 5'd11; ren_tag = 4'd2; cm_dst = 5'd9; cm_val = 32'h99; cm_tag = 4'd0;
        cyc(); rdy = 1'b1; q1_idx = 5'd11; q2_idx = 5'd9;
        #2; lit("x11_frozen", 1, 32'd0, 1'b0, 4'd0); lit("x9_kept", 2, 32'h55, 1'b0, 4'd0);

        // Asynchronous reset mid-cycle.
        ren_dst = 5'd12; ren_tag = 4'd3; cyc();
        q1_idx = 5'd12; q2_idx = 5'd6;
        #2; lit("x12_busy", 1, 32'd0, 1'b1, 4'd3); lit("x6_pre_rst", 2, 32'hAA, 1'b0, 4'd0);
        rst = 1'b1;
        #1; lit("x12_async_rst", 1, 32'd0, 1'b0, 4'd0); lit("x6_async_rst", 2, 32'd0, 1'b0, 4'd0);
        cyc(); rst = 1'b0;
        cyc();

        // Pseudo-random traffic over a small register window, checked by the model.
        for (int i = 0; i < 300; i++) begin
            rdy     = ($urandom_range(0, 7) != 0);
            misb    = ($urandom_range(0, 15) == 0);
            ren_dst = 5'($urandom_range(0, 7));
            ren_tag = 4'($urandom_range(0, 7));
            cm_dst  = 5'($urandom_range(0, 7));
            cm_val  = $urandom;
            cm_tag  = 4'($urandom_range(0, 7));
            q1_idx  = 5'($urandom_range(0, 7));
            q2_idx  = (i % 4 == 0) ? cm_dst : 5'($urandom_range(0, 7));
            @(posedge clk); #1;
        end
        idle(); rdy = 1'b1;
        @(negedge clk); #1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Safety net against a hung run.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule
